// File: rtl/wt_fifo_dual_if.sv
// wt_fifo_dual_if: dual-lane write/read valid-ready bus for wt_fifo_dual
interface wt_fifo_dual_if #(
  parameter int Width = 32
);
  logic [1:0]            wr_valid_i;
  logic [1:0][Width-1:0] wr_data_i;
  logic [1:0]            wr_rdy_o;
  logic [1:0]            rd_rdy_i;
  logic [1:0]            rd_valid_o;
  logic [1:0][Width-1:0] rd_data_o;
  modport master (
    output wr_valid_i, wr_data_i, rd_rdy_i,
    input  wr_rdy_o, rd_valid_o, rd_data_o
  );
  modport slave (
    input  wr_valid_i, wr_data_i, rd_rdy_i,
    output wr_rdy_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/wt_fifo_dual.sv
// wt_fifo_dual: dual-lane write-through FIFO with occupancy and synchronous flush
module wt_fifo_dual #(
  parameter int Depth  = 4,
  parameter int Width  = 32,
  parameter int Bypass = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  wt_fifo_dual_if.slave          bus,
  output logic [$clog2(Depth):0] level_o
);
  localparam int PtrW = $clog2(Depth) + 1;
  localparam int IdxW = PtrW - 1;
  localparam bit BypEn = (Bypass != 0);
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level, nw, nr;
  logic [Width-1:0]      mem_q [Depth];
  logic [IdxW-1:0]       wi0, wi1, ri0, ri1;
  logic                  stored0, stored1, wfire0, wfire1, rfire0, rfire1;
  logic [1:0]            wr_rdy, rd_valid;
  logic [1:0][Width-1:0] rd_data;
  assign level   = wr_ptr_q - rd_ptr_q;
  assign level_o = level;
  assign wi0 = wr_ptr_q[IdxW-1:0];
  assign wi1 = wi0 + 1'b1;
  assign ri0 = rd_ptr_q[IdxW-1:0];
  assign ri1 = ri0 + 1'b1;
  assign bus.wr_rdy_o   = wr_rdy;
  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_data_o  = rd_data;
  // Write acceptance looks only at registered occupancy, never at same-cycle reads
  always_comb begin
    wr_rdy = {level <= PtrW'(Depth - 2), level <= PtrW'(Depth - 1)};
    wfire0 = bus.wr_valid_i[0] & wr_rdy[0];
    wfire1 = wfire0 & bus.wr_valid_i[1] & wr_rdy[1];
    nw     = PtrW'(wfire0) + PtrW'(wfire1);
  end
  // Read view: stored entries first, then the write lanes when write-through is enabled
  always_comb begin
    stored0     = level != '0;
    stored1     = level > PtrW'(1);
    rd_valid[0] = stored0 | (BypEn & bus.wr_valid_i[0]);
    rd_valid[1] = stored1 | (BypEn & (level == '0 ? bus.wr_valid_i[1] : (level == PtrW'(1)) & bus.wr_valid_i[0]));
    rd_data[0]  = !rd_valid[0] ? '0 : stored0 ? mem_q[ri0] : bus.wr_data_i[0];
    rd_data[1]  = !rd_valid[1] ? '0 : stored1 ? mem_q[ri1] : bus.wr_data_i[level == '0 ? 1 : 0];
    rfire0      = rd_valid[0] & bus.rd_rdy_i[0];
    rfire1      = rfire0 & rd_valid[1] & bus.rd_rdy_i[1];
    nr          = PtrW'(rfire0) + PtrW'(rfire1);
  end
  // Pointer advance; flush discards every handshake of its cycle
  always_comb begin
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + nw;
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + nr;
  end
  // Pointer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // Storage; bypassed entries are written too and retired by the read pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= '{default: '0};
    else if (!flush_i) begin
      if (wfire0) mem_q[wi0] <= bus.wr_data_i[0];
      if (wfire1) mem_q[wi1] <= bus.wr_data_i[1];
    end
  end
  a_no_lane1_alone: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.wr_valid_i != 2'b10);
  a_hold_lane0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.wr_valid_i[0] && !wr_rdy[0] |=> !bus.wr_valid_i[0] || $stable(bus.wr_data_i[0]));
  a_hold_lane1: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.wr_valid_i[1] && !wr_rdy[1] |=> !bus.wr_valid_i[1] || $stable(bus.wr_data_i[1]));
  a_level_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    level <= PtrW'(Depth));
endmodule

// File: tb/tb_wt_fifo_dual.sv
// tb_wt_fifo_dual: scoreboard bench for wt_fifo_dual (Depth=4, Width=32, Bypass=1)
module tb_wt_fifo_dual;
  localparam int DEPTH = 4;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic [2:0]  level_o;
  logic [31:0] q[$];
  int          passed = 0;
  int          total = 0;
  wt_fifo_dual_if #(.Width(32)) bus ();
  wt_fifo_dual #(.Depth(DEPTH), .Width(32), .Bypass(1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush_i(flush_i),
    .bus    (bus),
    .level_o(level_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic step(input logic [1:0] wv, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] rr, input logic fl, input string tag);
    logic [31:0] view[$];
    int          nw, nr, lvl;
    logic [63:0] exp_d;
    @(negedge clk_i);
    bus.wr_valid_i = wv;
    bus.wr_data_i  = {d1, d0};
    bus.rd_rdy_i   = rr;
    flush_i        = fl;
    #1;
    lvl  = q.size();
    view = q;
    if (wv[0]) view.push_back(d0);
    if (wv[0] && wv[1]) view.push_back(d1);
    exp_d = {view.size() > 1 ? view[1] : 32'h0, view.size() > 0 ? view[0] : 32'h0};
    chk({tag, ".wr_rdy"}, 64'(bus.wr_rdy_o), 64'({lvl <= DEPTH - 2, lvl <= DEPTH - 1}));
    chk({tag, ".rd_valid"}, 64'(bus.rd_valid_o), 64'({view.size() > 1, view.size() > 0}));
    chk({tag, ".rd_data"}, bus.rd_data_o, exp_d);
    nw = (wv[0] && lvl <= DEPTH - 1) ? 1 + int'(wv[1] && lvl <= DEPTH - 2) : 0;
    nr = (rr[0] && view.size() > 0) ? 1 + int'(rr[1] && view.size() > 1) : 0;
    if (fl) q.delete();
    else begin
      if (nw > 0) q.push_back(d0);
      if (nw > 1) q.push_back(d1);
      repeat (nr) void'(q.pop_front());
    end
    @(posedge clk_i);
    #1;
    chk({tag, ".level"}, 64'(level_o), 64'(q.size()));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int nxt, n;
    rst_ni = 1'b0;
    flush_i = 1'b0;
    bus.wr_valid_i = 2'b00;
    bus.wr_data_i = '0;
    bus.rd_rdy_i = 2'b00;
    #2;
    chk("rst.level", 64'(level_o), 64'd0);
    chk("rst.wr_rdy", 64'(bus.wr_rdy_o), 64'd3);
    chk("rst.rd_valid", 64'(bus.rd_valid_o), 64'd0);
    chk("rst.rd_data", bus.rd_data_o, 64'd0);
    bus.wr_valid_i = 2'b11;
    bus.wr_data_i = {32'hB, 32'hA};
    #1;
    chk("rst.bypass_valid", 64'(bus.rd_valid_o), 64'd3);
    bus.wr_valid_i = 2'b00;
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2'b11, 32'hA, 32'hB, 2'b11, 1'b0, "bypass");
    step(2'b11, 32'h10, 32'h11, 2'b00, 1'b0, "fill1");
    step(2'b11, 32'h12, 32'h13, 2'b00, 1'b0, "fill2");
    step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, "full");
    step(2'b01, 32'h14, 32'h0, 2'b11, 1'b0, "full_rw");
    step(2'b00, 32'h0, 32'h0, 2'b01, 1'b0, "read1");
    step(2'b11, 32'h20, 32'h21, 2'b00, 1'b0, "fill3");
    step(2'b00, 32'h0, 32'h0, 2'b00, 1'b0, "lvl3");
    step(2'b11, 32'h30, 32'h31, 2'b00, 1'b1, "flush");
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, "post_flush");
    step(2'b01, 32'h40, 32'h0, 2'b00, 1'b0, "mix_x");
    step(2'b01, 32'h41, 32'h0, 2'b11, 1'b0, "mix_y");
    nxt = 0;
    for (int c = 0; c < 2000 && (nxt < 100 || q.size() > 0); c++) begin
      n = $urandom_range(0, 2);
      if (n > DEPTH - q.size()) n = DEPTH - q.size();
      if (n > 100 - nxt) n = 100 - nxt;
      step(n == 0 ? 2'b00 : n == 1 ? 2'b01 : 2'b11, nxt, nxt + 1,
           2'($urandom_range(0, 3)), 1'b0, "stream");
      nxt += n;
    end
    chk("stream.count", 64'(nxt), 64'd100);
    chk("stream.drained", 64'(level_o), 64'd0);
    step(2'b11, 32'h50, 32'h51, 2'b00, 1'b0, "pre_arst");
    bus.wr_valid_i = 2'b00;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst.level", 64'(level_o), 64'd0);
    chk("arst.rd_valid", 64'(bus.rd_valid_o), 64'd0);
    q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(2'b01, 32'h60, 32'h0, 2'b00, 1'b0, "arst_wr");
    step(2'b00, 32'h0, 32'h0, 2'b11, 1'b0, "arst_rd");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
